// File: rtl/l1_ahb_mtx_in_stage.sv
// L1 AHB bus matrix input stage: holds an address phase the target output port cannot take yet.
// Optional build macro L1_IN_STAGE_SEQ2NONSEQ_EN re-labels held SEQ beats after a lost grant as NONSEQ/INCR.
module l1_ahb_mtx_in_stage #(
    parameter int AW     = 32,
    parameter int RESP_W = 2
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              HSELS,
    input  logic [AW-1:0]     HADDRS,
    input  logic [1:0]        HTRANSS,
    input  logic              HWRITES,
    input  logic [2:0]        HSIZES,
    input  logic [2:0]        HBURSTS,
    input  logic [3:0]        HPROTS,
    input  logic              HMASTLOCKS,
    input  logic              HREADYS,
    input  logic              active_addr,
    input  logic              HREADYM,
    input  logic              readyout_dp,
    input  logic [RESP_W-1:0] resp_dp,
    output logic              sel_m,
    output logic [AW-1:0]     HADDRM,
    output logic [1:0]        HTRANSM,
    output logic              HWRITEM,
    output logic [2:0]        HSIZEM,
    output logic [2:0]        HBURSTM,
    output logic [3:0]        HPROTM,
    output logic              HMASTLOCKM,
    output logic              HREADYOUTS,
    output logic [RESP_W-1:0] HRESPS
);

    localparam logic [1:0]        TR_IDLE    = 2'b00;
    localparam logic [1:0]        TR_NONSEQ  = 2'b10;
    localparam logic [1:0]        TR_SEQ     = 2'b11;
    localparam logic [2:0]        BURST_INCR = 3'b001;
    localparam logic [RESP_W-1:0] RESP_OKAY  = '0;
    localparam logic [RESP_W-1:0] RESP_ERROR = RESP_W'(1);

    logic              pend_q, pend_d;
    logic              dp_active_q, dp_active_d;
    logic              cancel_q, cancel_d;
    logic [AW-1:0]     haddr_q, haddr_d;
    logic [1:0]        htrans_q, htrans_d;
    logic              hwrite_q, hwrite_d;
    logic [2:0]        hsize_q, hsize_d;
    logic [2:0]        hburst_q, hburst_d;
    logic [3:0]        hprot_q, hprot_d;
    logic              hlock_q, hlock_d;

    logic              trans_valid;
    logic              live_gate;
    logic              accept;
    logic              err_first;
    logic              discard;
    logic              pend_vis;
    logic [1:0]        held_trans;
    logic [2:0]        held_burst;

    assign live_gate   = HSELS & HREADYS;
    assign trans_valid = live_gate & HTRANSS[1];
    assign accept      = active_addr & HREADYM;

    // An ERROR on the running data phase kills the queued transfer: it is hidden
    // from the arbiters at once and dropped when the second ERROR cycle completes.
    assign err_first = pend_q & dp_active_q & (resp_dp == RESP_ERROR) & ~readyout_dp;
    assign discard   = cancel_q | err_first;
    assign pend_vis  = pend_q & ~discard;
    assign sel_m     = pend_vis | trans_valid;

`ifdef L1_IN_STAGE_SEQ2NONSEQ_EN
    logic lost_grant_q;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            lost_grant_q <= 1'b0;
        end else begin
            lost_grant_q <= sel_m & ~accept;
        end
    end

    // A held SEQ beat that lost arbitration restarts as an undefined-length burst.
    always_comb begin
        held_trans = htrans_q;
        held_burst = hburst_q;
        if ((htrans_q == TR_SEQ) && lost_grant_q) begin
            held_trans = TR_NONSEQ;
            held_burst = BURST_INCR;
        end
    end
`else
    assign held_trans = htrans_q;
    assign held_burst = hburst_q;
`endif

    always_comb begin
        pend_d   = pend_q;
        cancel_d = pend_q & discard & ~readyout_dp;
        haddr_d  = haddr_q;
        htrans_d = htrans_q;
        hwrite_d = hwrite_q;
        hsize_d  = hsize_q;
        hburst_d = hburst_q;
        hprot_d  = hprot_q;
        hlock_d  = hlock_q;
        if (pend_q) begin
            if (discard) begin
                if (readyout_dp) begin
                    pend_d = 1'b0;
                end
            end else if (accept) begin
                pend_d = 1'b0;
            end
        end else if (trans_valid && !accept) begin
            pend_d   = 1'b1;
            haddr_d  = HADDRS;
            htrans_d = HTRANSS;
            hwrite_d = HWRITES;
            hsize_d  = HSIZES;
            hburst_d = HBURSTS;
            hprot_d  = HPROTS;
            hlock_d  = HMASTLOCKS;
        end
    end

    always_comb begin
        dp_active_d = dp_active_q;
        if (sel_m && accept) begin
            dp_active_d = 1'b1;
        end else if (HREADYM) begin
            dp_active_d = 1'b0;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pend_q      <= 1'b0;
            cancel_q    <= 1'b0;
            dp_active_q <= 1'b0;
            haddr_q     <= '0;
            htrans_q    <= TR_IDLE;
            hwrite_q    <= 1'b0;
            hsize_q     <= '0;
            hburst_q    <= '0;
            hprot_q     <= '0;
            hlock_q     <= 1'b0;
        end else begin
            pend_q      <= pend_d;
            cancel_q    <= cancel_d;
            dp_active_q <= dp_active_d;
            haddr_q     <= haddr_d;
            htrans_q    <= htrans_d;
            hwrite_q    <= hwrite_d;
            hsize_q     <= hsize_d;
            hburst_q    <= hburst_d;
            hprot_q     <= hprot_d;
            hlock_q     <= hlock_d;
        end
    end

    always_comb begin
        if (pend_vis) begin
            HADDRM     = haddr_q;
            HTRANSM    = held_trans;
            HWRITEM    = hwrite_q;
            HSIZEM     = hsize_q;
            HBURSTM    = held_burst;
            HPROTM     = hprot_q;
            HMASTLOCKM = hlock_q;
        end else begin
            HADDRM     = HADDRS;
            HTRANSM    = live_gate ? HTRANSS : TR_IDLE;
            HWRITEM    = HWRITES;
            HSIZEM     = HSIZES;
            HBURSTM    = HBURSTS;
            HPROTM     = HPROTS;
            HMASTLOCKM = HMASTLOCKS;
        end
    end

    always_comb begin
        if (dp_active_q) begin
            HREADYOUTS = readyout_dp;
        end else begin
            HREADYOUTS = ~pend_q;
        end
    end

    assign HRESPS = dp_active_q ? resp_dp : RESP_OKAY;

endmodule

// File: doc/l1_ahb_mtx_in_stage.md
Name: l1_ahb_mtx_in_stage

Overview:
- Input stage of the L1 AHB bus matrix. One instance per slave-side (master-facing) port.
- Buffers an address phase that the addressed output port cannot accept yet, and raises that port's request. The request feeds the output arbiters.
- Presents either the held or the live address-phase signals to the output stage, and returns the data-phase ready/response to the master.

Parameters:
- AW, 32, address width.
- RESP_W, 2, HRESP width (OKAY=0, ERROR=1).

Ports:
- HCLK  in  1  AHB clock.
- HRESETn  in  1  reset, asynchronous, active-low.
- HSELS  in  1  port select from master side.
- HADDRS  in  AW  address.
- HTRANSS  in  2  transfer type.
- HWRITES  in  1  write.
- HSIZES  in  3  size.
- HBURSTS  in  3  burst.
- HPROTS  in  4  protection.
- HMASTLOCKS  in  1  locked.
- HREADYS  in  1  system HREADY (previous transfer complete).
- active_addr  in  1  output arbiter has granted this stage this cycle (its addr_in_port equals this port).
- HREADYM  in  1  HREADY of the currently selected output port.
- readyout_dp  in  1  data-phase HREADYOUT routed back from the output port.
- resp_dp  in  RESP_W  data-phase HRESP routed back.
- sel_m  out  1  valid address phase presented (request to arbiters).
- HADDRM  out  AW  presented address.
- HTRANSM  out  2  presented transfer type.
- HWRITEM  out  1  presented write.
- HSIZEM  out  3  presented size.
- HBURSTM  out  3  presented burst.
- HPROTM  out  4  presented protection.
- HMASTLOCKM  out  1  presented lock.
- HREADYOUTS  out  1  ready to master.
- HRESPS  out  RESP_W  response to master.

Behaviour:
- Live transfer: trans_valid = HSELS & HREADYS & HTRANSS[1]. IDLE and BUSY never request.
- Hold register: captures HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS and HMASTLOCKS on a posedge with trans_valid=1 and accept=0, where accept = active_addr & HREADYM. Capture sets pend=1.
- pend clears on the posedge where active_addr & HREADYM = 1. Held fields are don't-care while pend=0.
- Output mux:
  - pend=1: outputs = held fields.
  - pend=0: outputs = live inputs, gated by HSELS & HREADYS. When the gate is 0, HTRANSM is forced to IDLE.
  - sel_m = pend | trans_valid (combinational).
- Data-phase tracker dp_active, registered, reset 0:
  - Set on posedge where sel_m & active_addr & HREADYM = 1.
  - Cleared on posedge where HREADYM & ~(sel_m & active_addr).
- HREADYOUTS:
  - dp_active=1: equals readyout_dp.
  - else pend=1: 0.
  - else: 1.
- HRESPS = resp_dp when dp_active=1, else OKAY.
- Two-cycle ERROR: if resp_dp=ERROR with readyout_dp=0 while a transfer is pending, the pending transfer is discarded. pend clears on the following posedge where readyout_dp=1, and it is never presented to an arbiter after that.
- Simultaneous capture and accept in the same cycle: the live transfer passes straight through and pend stays 0.
- Reset values:
  - pend=0, dp_active=0, hold register 0.
  - HREADYOUTS=1, HRESPS=0, sel_m=0, HTRANSM=IDLE.
  - A reset asserted mid-transfer drops any held transfer immediately (asynchronous).
- Latency: zero added cycles when granted; otherwise one held cycle per cycle of non-grant.

Optional Feature:
- Macro L1_IN_STAGE_SEQ2NONSEQ_EN.
- With the macro defined: when a held transfer has HTRANS=SEQ and the stage was not granted on the previous cycle (registered flag lost_grant), HTRANSM is presented as NONSEQ and HBURSTM as INCR (3'b001). This stops an arbiter burst counter from mis-tracking a broken burst.
- Without the macro: held fields are presented unmodified.

Test Plan:
- Granted single: HSELS=1, HTRANSS=NONSEQ, HADDRS=0x2000_0010, active_addr=1, HREADYM=1 → same cycle HTRANSM=NONSEQ and HADDRM=0x2000_0010; next cycle dp_active=1 and HREADYOUTS follows readyout_dp.
- Held transfer: same stimulus with active_addr=0 for 3 cycles → HREADYOUTS=0 for 3 cycles and HADDRM stays 0x2000_0010 while live inputs change to 0xFFFF_FFFF. Grant on cycle 4 → pend=0; HREADYOUTS follows readyout_dp the next cycle.
- IDLE/BUSY: HTRANSS=BUSY with HSELS=1 → sel_m=0, no capture, HREADYOUTS=1.
- Error cancel: dp_active=1, new transfer pending, resp_dp=ERROR with readyout_dp=0 then 1 → HRESPS=ERROR for both cycles, pend=0 afterwards, sel_m=0.
- Async reset: assert HRESETn=0 mid-cycle with pend=1 → immediately HREADYOUTS=1, sel_m=0, HTRANSM=IDLE.
- With L1_IN_STAGE_SEQ2NONSEQ_EN: held SEQ INCR4 beat, grant lost for 1 cycle → HTRANSM=NONSEQ, HBURSTM=3'b001. Without the macro → HTRANSM=SEQ, HBURSTM=3'b011.
